// File: rtl/scs8hd_arb3b_rr_1.sv
//------------------------------------------------------------------------------
// Module   : scs8hd_arb3b_rr_1
// Brief    : 3-way round-robin arbiter (A, B active-high; CN active-low) with
//            hold-time preemption. Optional LOCK input via SCS8HD_ARB_LOCK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module scs8hd_arb3b_rr_1 #(
    parameter int MAXHOLD = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic A,
    input  logic B,
    input  logic CN,
`ifdef SCS8HD_ARB_LOCK_EN
    input  logic LOCK,
`endif
    output logic GA,
    output logic GB,
    output logic GC,
    output logic BUSY,
    output logic X
);

    localparam logic [3:0] c_hold_max = 4'(MAXHOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_last;
    logic [1:0] w_last_nxt;
    logic [3:0] r_hold;
    logic [3:0] w_hold_nxt;
    logic [2:0] r_gnt;
    logic [2:0] w_gnt_nxt;
    logic       r_busy;

    logic [2:0] w_req;
    logic [2:0] w_others;
    logic [2:0] w_mask;
    logic [1:0] w_nxt1;
    logic [1:0] w_nxt2;
    logic       w_pick_valid;
    logic [1:0] w_pick_idx;
    logic       w_lock;

    assign w_req = {~CN, B, A};

`ifdef SCS8HD_ARB_LOCK_EN
    assign w_lock = LOCK;
`else
    assign w_lock = 1'b0;
`endif

    // Rotation order after the last owner: nxt1, nxt2, then the last owner itself.
    assign w_nxt1   = (r_last == 2'd2) ? 2'd0 : r_last + 2'd1;
    assign w_nxt2   = (w_nxt1 == 2'd2) ? 2'd0 : w_nxt1 + 2'd1;
    assign w_others = w_req & ~(3'b001 << r_last);
    assign w_mask   = (r_state == ST_OWN) ? w_others : w_req;

    always_comb begin
        w_pick_valid = 1'b1;
        w_pick_idx   = r_last;
        if (w_mask[w_nxt1]) begin
            w_pick_idx = w_nxt1;
        end else if (w_mask[w_nxt2]) begin
            w_pick_idx = w_nxt2;
        end else if (w_mask[r_last]) begin
            w_pick_idx = r_last;
        end else begin
            w_pick_valid = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_OWN;
                    w_last_nxt  = w_pick_idx;
                    w_hold_nxt  = 4'd0;
                end
            end
            ST_OWN: begin
                if (!w_req[r_last]) begin
                    w_hold_nxt = 4'd0;
                    if (w_pick_valid) begin
                        w_last_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if ((r_hold == c_hold_max) && w_pick_valid && !w_lock) begin
                    w_last_nxt = w_pick_idx;
                    w_hold_nxt = 4'd0;
                end else if (r_hold != c_hold_max) begin
                    w_hold_nxt = r_hold + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_gnt_nxt = (w_state_nxt == ST_OWN) ? (3'b001 << w_last_nxt) : 3'b000;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd2;
            r_hold  <= 4'd0;
            r_gnt   <= 3'b000;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= |w_gnt_nxt;
        end
    end

    assign GA   = r_gnt[0];
    assign GB   = r_gnt[1];
    assign GC   = r_gnt[2];
    assign BUSY = r_busy;
    assign X    = A | B | ~CN;

endmodule

`default_nettype wire

// File: tb/tb_scs8hd_arb3b_rr_1.sv
//------------------------------------------------------------------------------
// Module   : tb_scs8hd_arb3b_rr_1
// Brief    : Directed bench for scs8hd_arb3b_rr_1 (MAXHOLD=8 and MAXHOLD=1 copies).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_scs8hd_arb3b_rr_1;

    logic CLK;
    logic RESET;
    logic A;
    logic B;
    logic CN;
    logic LOCK;
    logic GA, GB, GC, BUSY, X;
    logic GA1, GB1, GC1, BUSY1, X1;

    int n_assert;
    int n_fail;

    scs8hd_arb3b_rr_1 #(.MAXHOLD(8)) u_dut (
        .CLK  (CLK),
        .RESET(RESET),
        .A    (A),
        .B    (B),
        .CN   (CN),
`ifdef SCS8HD_ARB_LOCK_EN
        .LOCK (LOCK),
`endif
        .GA   (GA),
        .GB   (GB),
        .GC   (GC),
        .BUSY (BUSY),
        .X    (X)
    );

    scs8hd_arb3b_rr_1 #(.MAXHOLD(1)) u_dut1 (
        .CLK  (CLK),
        .RESET(RESET),
        .A    (A),
        .B    (B),
        .CN   (CN),
`ifdef SCS8HD_ARB_LOCK_EN
        .LOCK (LOCK),
`endif
        .GA   (GA1),
        .GB   (GB1),
        .GC   (GC1),
        .BUSY (BUSY1),
        .X    (X1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Observed/expected packed as {BUSY, GC, GB, GA}
    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] own(input int idx);
        return {1'b1, 3'(3'b001 << idx)};
    endfunction

    initial begin
        n_assert = 0;
        n_fail   = 0;
        RESET = 1'b1; A = 1'b0; B = 1'b0; CN = 1'b1; LOCK = 1'b0;
        step();
        step();
        chk("reset_state", {BUSY, GC, GB, GA}, 4'b0000);

        // Requests are ignored on a reset edge
        A = 1'b1;
        #1;
        chk("x_during_reset", {3'b000, X}, 4'b0001);
        step();
        chk("req_ignored_in_reset", {BUSY, GC, GB, GA}, 4'b0000);

        // First grant goes to A with one-cycle latency
        RESET = 1'b0;
        #1;
        chk("x_immediate", {3'b000, X}, 4'b0001);
        chk("no_grant_before_edge", {BUSY, GC, GB, GA}, 4'b0000);
        step();
        chk("first_grant_a", {BUSY, GC, GB, GA}, 4'b1001);

        // A drops with nothing pending -> idle, then CN low -> C (rotation after A)
        A = 1'b0;
        step();
        chk("release_to_idle", {BUSY, GC, GB, GA}, 4'b0000);
        #1;
        chk("x_idle_low", {3'b000, X}, 4'b0000);
        CN = 1'b0;
        step();
        chk("idle_then_c", {BUSY, GC, GB, GA}, 4'b1100);
        CN = 1'b1;
        step();
        chk("c_release", {BUSY, GC, GB, GA}, 4'b0000);

        // Full contention from reset: 8-cycle slots A,B,C,A; MAXHOLD=1 rotates every cycle
        RESET = 1'b1;
        step();
        RESET = 1'b0; A = 1'b1; B = 1'b1; CN = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            step();
            chk($sformatf("rr8_cyc%0d", k), {BUSY, GC, GB, GA}, own(((k - 1) / 8) % 3));
            chk($sformatf("rr1_cyc%0d", k), {BUSY1, GC1, GB1, GA1}, own((k - 1) % 3));
        end

        // B held; B drops while CN low -> direct handover to C, BUSY stays high
        RESET = 1'b1; A = 1'b0; B = 1'b0; CN = 1'b1;
        step();
        RESET = 1'b0; B = 1'b1;
        step();
        chk("b_granted", {BUSY, GC, GB, GA}, 4'b1010);
        CN = 1'b0;
        step();
        chk("b_kept_under_c", {BUSY, GC, GB, GA}, 4'b1010);
        B = 1'b0;
        step();
        chk("b_to_c_handover", {BUSY, GC, GB, GA}, 4'b1100);

        // Reset pulse during C ownership; A=1 afterwards -> A
        step();
        chk("c_held", {BUSY, GC, GB, GA}, 4'b1100);
        RESET = 1'b1;
        step();
        chk("reset_drops_c", {BUSY, GC, GB, GA}, 4'b0000);
        RESET = 1'b0; A = 1'b1;
        step();
        chk("post_reset_a", {BUSY, GC, GB, GA}, 4'b1001);

        // Reset pulse with only CN low -> C regains the grant
        A = 1'b0;
        RESET = 1'b1;
        step();
        chk("reset_again", {BUSY, GC, GB, GA}, 4'b0000);
        RESET = 1'b0;
        step();
        chk("post_reset_c", {BUSY, GC, GB, GA}, 4'b1100);

        // Lone requester keeps its grant past MAXHOLD; then A arrives -> preempt at once
        CN = 1'b1;
        RESET = 1'b1;
        step();
        RESET = 1'b0; B = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
        end
        chk("b_held_20", {BUSY, GC, GB, GA}, 4'b1010);
        A = 1'b1;
        step();
        chk("saturated_preempt_a", {BUSY, GC, GB, GA}, 4'b1001);
        step();
        chk("a_after_preempt", {BUSY, GC, GB, GA}, 4'b1001);

`ifdef SCS8HD_ARB_LOCK_EN
        // LOCK holds A beyond MAXHOLD; releasing LOCK preempts to B at the next edge
        RESET = 1'b1;
        step();
        RESET = 1'b0; A = 1'b1; B = 1'b1; CN = 1'b1; LOCK = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
        end
        chk("lock_a_held_20", {BUSY, GC, GB, GA}, 4'b1001);
        LOCK = 1'b0;
        step();
        chk("unlock_to_b", {BUSY, GC, GB, GA}, 4'b1010);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
